chan_scan_ctrl: RTL and testbench
=================================

CHAN_SCAN_CTRL -- requirements
Module: chan_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst; all state SHALL update only on the rising edge of clk.
REQ-002 Parameter DWELL_W, default 8, SHALL set the width of the dwell count.
REQ-003 Port clk, input, 1 bit: the rising-edge clock.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port en, input, 1 bit: scan enable.
REQ-006 Port req, input, 4 bits: per-channel request; bit i is channel i (i = 0 to 3).
REQ-007 Port dwell, input, DWELL_W bits: hold length in cycles for each grant.
REQ-008 Port s1, output, 1 bit: mux select LSB.
REQ-009 Port s2, output, 1 bit: mux select MSB; {s2,s1} SHALL equal the granted channel index.
REQ-010 Port sel_valid, output, 1 bit: high while a grant is held.
REQ-011 Port grant, output, 4 bits: one-hot copy of the granted channel; all zeros when sel_valid=0.
REQ-012 Port done, output, 1 bit: one-cycle pulse in the last cycle of each grant.

Function
REQ-013 FSM states SHALL be IDLE and HOLD.
REQ-014 IDLE to HOLD: the block SHALL leave IDLE when en=1 and req!=0 at a clock edge; grant, s1/s2 and sel_valid=1 SHALL be visible in the next cycle (1-cycle latency).
REQ-015 The channel SHALL be picked round-robin: search starts at (last granted index + 1) mod 4 and takes the first set req bit.
REQ-016 After reset, the last granted index SHALL be 3, so the search starts at channel 0.
REQ-017 On each grant, the block SHALL sample dwell and load a down-counter with max(dwell,1)-1; dwell=0 SHALL behave as dwell=1.
REQ-018 The block SHALL ignore dwell changes during HOLD.
REQ-019 In HOLD, the counter SHALL decrement each cycle; s1, s2 and grant SHALL stay stable.
REQ-020 When the counter is 0 in HOLD, done SHALL be 1 for that cycle.
REQ-021 At that edge, if en=1 and req!=0, the block SHALL re-pick and reload with no bubble cycle (back-to-back grants).
REQ-022 At that edge, otherwise, the FSM SHALL go to IDLE; sel_valid and grant SHALL clear and s1/s2 SHALL keep their last value.
REQ-023 If en falls during HOLD, the current dwell SHALL complete before the block stops.
REQ-024 If req drops during HOLD, behaviour SHALL follow REQ-032 and REQ-033.
REQ-025 If only one channel requests, that channel SHALL be re-granted repeatedly.
REQ-026 The counter SHALL saturate correctly at the maximum dwell of 2^DWELL_W-1 without wrap-around.

Reset
REQ-027 While rst=1, state SHALL be IDLE, s1=0, s2=0, sel_valid=0, grant=0, done=0 and counter=0, with the last granted index set to 3.
REQ-028 Reset SHALL take priority over all other inputs.
REQ-029 Reset asserted mid-HOLD SHALL abort the grant with no done pulse.
REQ-030 The first cycle after rst falls SHALL be treated as IDLE.

Configuration
REQ-031 Macro SCAN_ABORT_EN SHALL compile early abort in or out.
REQ-032 With SCAN_ABORT_EN defined: if the granted channel's req bit is 0 during HOLD, the counter SHALL be forced to 0 at the next edge; done SHALL pulse in the cycle after that edge, and then REQ-021/REQ-022 apply.
REQ-033 Without SCAN_ABORT_EN: the full dwell SHALL always complete regardless of req.

Structure
REQ-034 A shared package chan_scan_pkg SHALL hold NUM_CH=4, SEL_W=2 and the state encoding (IDLE=0, HOLD=1).
REQ-035 One combinational sub-module rr_pick SHALL take (req, last_idx) and return (idx, any).

Verification
REQ-036 Reset check: rst=1 for 3 cycles -> s1=s2=sel_valid=done=0 and grant=0000.
REQ-037 Two-channel scan: req=0101, dwell=3, en=1 -> grant 0001 for 3 cycles, then 0100 for 3 cycles, repeating; {s2,s1}=00 then 10; done high every 3rd cycle.
REQ-038 Full scan: req=1111, dwell=0 -> {s2,s1} = 00,01,10,11,00 on consecutive cycles; done continuously high.
REQ-039 Enable drop: en falls on cycle 2 of a dwell=5 grant -> the grant completes all 5 cycles, then IDLE with sel_valid=0.
REQ-040 Mid-HOLD reset: rst=1 on cycle 2 of a dwell=4 grant on channel 2 -> all outputs 0 next cycle, no done pulse; the next grant starts at channel 0.
REQ-041 Abort (SCAN_ABORT_EN defined): req[1] drops on cycle 1 of a dwell=8 grant on channel 1 -> done in the following cycle, then the next requester is granted. Without the macro, the same stimulus SHALL give 8 held cycles.

Source files
------------

// File: rtl/chan_scan_pkg.sv
// Shared definitions for the channel scan controller.
//   NUM_CH  : number of scanned channels
//   SEL_W   : width of the channel index / mux select
//   state_t : controller FSM encoding (IDLE=0, HOLD=1)
//   onehot(): index to one-hot channel mask
package chan_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction
endpackage

// File: rtl/chan_scan_ctrl_rr_pick.sv
// rr_pick: combinational round-robin channel picker.
//   req      : per-channel request mask
//   last_idx : most recently granted channel
//   idx      : first requesting channel after last_idx (wrapping)
//   any      : at least one request is set (idx is meaningful only then)
module rr_pick
  import chan_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_idx,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);
  always_comb begin
    idx = last_idx;
    any = |req;
    // Walk from the farthest candidate back to the nearest so the channel
    // closest after last_idx overwrites the others. SEL_W-bit add wraps mod 4.
    for (int i = NUM_CH; i >= 1; i--) begin
      if (req[last_idx + SEL_W'(i)]) idx = last_idx + SEL_W'(i);
    end
  end
endmodule

// File: rtl/chan_scan_ctrl.sv
// chan_scan_ctrl: round-robin channel scanner with per-grant dwell.
//   clk, rst   : clock, synchronous active-high reset
//   en         : scan enable (sampled only when a new grant may start)
//   req        : per-channel request mask
//   dwell      : grant length in cycles, sampled at grant start (0 acts as 1)
//   s2,s1      : granted channel index (held after the scan stops)
//   sel_valid  : a grant is being held
//   grant      : one-hot granted channel, zero when idle
//   done       : pulses in the final cycle of each grant
// Optional: define SCAN_ABORT_EN to end a grant early when the granted
// channel's request drops.
module chan_scan_ctrl
  import chan_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_CH-1:0]  req,
  input  logic [DWELL_W-1:0] dwell,
  output logic               s1,
  output logic               s2,
  output logic               sel_valid,
  output logic [NUM_CH-1:0]  grant,
  output logic               done
);
  state_t             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n, load;
  logic [SEL_W-1:0]   idx, idx_n, last, last_n;
  logic [NUM_CH-1:0]  grant_n;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               last_cyc, start, abort;

  rr_pick u_pick (
    .req      (req),
    .last_idx (last),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // dwell-1 never exceeds the counter range, so max dwell needs no wrap guard.
  assign load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

`ifdef SCAN_ABORT_EN
  assign abort = (state == HOLD) && !req[idx];
`else
  assign abort = 1'b0;
`endif

  assign last_cyc = (state == HOLD) && (cnt == '0);
  // A grant can start from IDLE or seamlessly on the last cycle of a hold.
  assign start    = en && pick_any && ((state == IDLE) || last_cyc);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    last_n  = last;
    grant_n = grant;
    if (start) begin
      state_n = HOLD;
      cnt_n   = load;
      idx_n   = pick_idx;
      last_n  = pick_idx;
      grant_n = onehot(pick_idx);
    end else if (last_cyc) begin
      state_n = IDLE;
      grant_n = '0;
    end else if (state == HOLD) begin
      // Forcing the counter to 0 puts done in the following cycle.
      cnt_n = abort ? '0 : cnt - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      last  <= SEL_W'(NUM_CH - 1);
      grant <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      last  <= last_n;
      grant <= grant_n;
    end
  end

  assign s1        = idx[0];
  assign s2        = idx[1];
  assign sel_valid = (state == HOLD);
  // Gated so a reset landing on a final hold cycle produces no pulse.
  assign done      = last_cyc && !rst;
endmodule

// File: tb/tb_chan_scan_ctrl.sv
// Directed bench for chan_scan_ctrl: vector table plus hand-written
// multi-cycle sequences (enable drop, max dwell, mid-hold reset, abort).
module tb_chan_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] req;
  logic [7:0] dwell;
  logic       s1, s2, sel_valid, done;
  logic [3:0] grant;

  int checks = 0;
  int errors = 0;

  chan_scan_ctrl #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .dwell(dwell),
    .s1(s1), .s2(s2), .sel_valid(sel_valid), .grant(grant), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en;
    logic [3:0] req;
    logic [7:0] dwell;
    logic [1:0] s;
    logic       v;
    logic [3:0] g;
    logic       d;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [3:0] q, logic [7:0] dw,
                              logic [1:0] s, logic v, logic [3:0] g, logic d);
    vec_t x;
    x.rst = r; x.en = e; x.req = q; x.dwell = dw;
    x.s = s; x.v = v; x.g = g; x.d = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive cycles holding grant g (and done pulses within them).
  task automatic measure(input logic [3:0] g, output int held, output int dn);
    held = 0;
    dn   = 0;
    for (int k = 0; k < 400; k++) begin
      if (grant !== g) break;
      held++;
      if (done) dn++;
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 4'b0000; dwell = 8'd0;
    step();
    rst = 1'b0;
  endtask

  int held, dn;

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000; dwell = 8'd0;

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 4'b0000, 0, 2'b00, 0, 4'b0000, 0));
    // two-channel scan, dwell 3
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk(0, 1, 4'b0101, 3, 2'b00, 1, 4'b0001, 0));
      vecs.push_back(mk(0, 1, 4'b0101, 3, 2'b00, 1, 4'b0001, 0));
      vecs.push_back(mk(0, 1, 4'b0101, 3, 2'b00, 1, 4'b0001, 1));
      if (r == 0) begin
        vecs.push_back(mk(0, 1, 4'b0101, 3, 2'b10, 1, 4'b0100, 0));
        vecs.push_back(mk(0, 1, 4'b0101, 3, 2'b10, 1, 4'b0100, 0));
        vecs.push_back(mk(0, 1, 4'b0101, 3, 2'b10, 1, 4'b0100, 1));
      end
    end
    vecs.push_back(mk(1, 0, 4'b0000, 0, 2'b00, 0, 4'b0000, 0));
    // full scan, dwell 0 acts as 1: one grant per cycle
    vecs.push_back(mk(0, 1, 4'b1111, 0, 2'b00, 1, 4'b0001, 1));
    vecs.push_back(mk(0, 1, 4'b1111, 0, 2'b01, 1, 4'b0010, 1));
    vecs.push_back(mk(0, 1, 4'b1111, 0, 2'b10, 1, 4'b0100, 1));
    vecs.push_back(mk(0, 1, 4'b1111, 0, 2'b11, 1, 4'b1000, 1));
    vecs.push_back(mk(0, 1, 4'b1111, 0, 2'b00, 1, 4'b0001, 1));
    vecs.push_back(mk(0, 1, 4'b1111, 0, 2'b01, 1, 4'b0010, 1));
    // stop: select index kept, valid/grant cleared
    vecs.push_back(mk(0, 0, 4'b0000, 0, 2'b01, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 2'b01, 0, 4'b0000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; req = vecs[i].req; dwell = vecs[i].dwell;
      step();
      chk($sformatf("vec%0d_sel", i),   {30'd0, s2, s1}, {30'd0, vecs[i].s});
      chk($sformatf("vec%0d_valid", i), {31'd0, sel_valid}, {31'd0, vecs[i].v});
      chk($sformatf("vec%0d_grant", i), {28'd0, grant}, {28'd0, vecs[i].g});
      chk($sformatf("vec%0d_done", i),  {31'd0, done}, {31'd0, vecs[i].d});
    end

    // enable drop on cycle 2 of a dwell=5 grant; dwell change ignored
    do_reset();
    en = 1'b1; req = 4'b0001; dwell = 8'd5;
    step();
    step();
    en = 1'b0; dwell = 8'd2;
    measure(4'b0001, held, dn);
    chk("endrop_held", held + 1, 5);
    chk("endrop_done", dn, 1);
    chk("endrop_idle", {31'd0, sel_valid}, 0);

    // maximum dwell, no wrap
    do_reset();
    en = 1'b1; req = 4'b0001; dwell = 8'd255;
    step();
    en = 1'b0;
    measure(4'b0001, held, dn);
    chk("maxdwell_held", held, 255);
    chk("maxdwell_done", dn, 1);

    // reset on cycle 2 of a dwell=4 grant on channel 2
    do_reset();
    en = 1'b1; req = 4'b0100; dwell = 8'd4;
    step();
    chk("midrst_grant", {28'd0, grant}, 32'b0100);
    chk("midrst_sel", {30'd0, s2, s1}, 2);
    step();
    rst = 1'b1;
    #1;
    chk("midrst_nodone", {31'd0, done}, 0);
    step();
    chk("midrst_outs", {24'd0, s2, s1, sel_valid, done, grant}, 0);
    rst = 1'b0; req = 4'b0101;
    step();
    chk("midrst_next", {28'd0, grant}, 32'b0001);

    // request drop on cycle 1 of a dwell=8 grant on channel 1
    do_reset();
    en = 1'b1; req = 4'b1010; dwell = 8'd8;
    step();
    chk("abort_grant", {28'd0, grant}, 32'b0010);
    req = 4'b1000;
    measure(4'b0010, held, dn);
`ifdef SCAN_ABORT_EN
    chk("abort_held", held, 2);
`else
    chk("abort_held", held, 8);
`endif
    chk("abort_done", dn, 1);
    chk("abort_next", {28'd0, grant}, 32'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
